// File: rtl/io_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : io_bridge_if
//  Description : CPU-side request/response and device-side bus signals of
//                the IO bridge, bundled with bridge (slave) and environment
//                (master) views.
//  Revision    : 1.0  initial release
// ============================================================================
interface io_bridge_if;
  // CPU request
  logic        cpu_req;
  logic        cpu_we;
  logic [31:2] cpu_addr;
  logic [3:0]  cpu_byteen;
  logic [31:0] cpu_wdata;
  // CPU response
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        bus_err;
  // Device side
  logic [31:2] dev_addr;
  logic [31:0] dev_wdata;
  logic [3:0]  dev_byteen;
  logic        timer_wen;
  logic        tube_wen;
  logic        tube_en;
  logic [31:0] timer_rdata;
  logic [31:0] sw_rdata;
  logic [31:0] tube_rdata;

  // The bridge itself
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_byteen, cpu_wdata,
    input  timer_rdata, sw_rdata, tube_rdata,
    output cpu_ready, cpu_rvalid, cpu_rdata, bus_err,
    output dev_addr, dev_wdata, dev_byteen, timer_wen, tube_wen, tube_en
  );

  // The CPU plus devices surrounding the bridge
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_byteen, cpu_wdata,
    output timer_rdata, sw_rdata, tube_rdata,
    input  cpu_ready, cpu_rvalid, cpu_rdata, bus_err,
    input  dev_addr, dev_wdata, dev_byteen, timer_wen, tube_wen, tube_en
  );
endinterface
`default_nettype wire

// File: rtl/io_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : io_bridge
//  Description : CPU to memory-mapped IO bridge. Posted writes pass through a
//                2-entry FIFO to timer/tube strobes (or the internal display
//                enable); reads wait for all writes to complete and return
//                registered device data one cycle after acceptance.
//  Revision    : 1.0  initial release
// ============================================================================
module io_bridge #(
  parameter logic [31:0] TIMER_BASE = 32'h0000_7F00,
  parameter logic [31:0] SW_BASE    = 32'h0000_7F2C,
  parameter logic [31:0] TUBE_BASE  = 32'h0000_7F50,
  parameter logic [31:0] TUBE_CTL   = 32'h0000_7F58
) (
  input  logic       clk,
  input  logic       reset,
  io_bridge_if.slave bus
);

  typedef enum logic [2:0] {
    TGT_NONE  = 3'd0,
    TGT_TIMER = 3'd1,
    TGT_SW    = 3'd2,
    TGT_TUBE  = 3'd3,
    TGT_CTL   = 3'd4
  } target_t;

  typedef struct packed {
    logic [31:2] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    target_t     target;
  } entry_t;

  // Address decode on the word address; anything outside the four windows
  // is unmapped.
  function automatic target_t decode(input logic [31:2] waddr);
    logic [31:0] a;
    target_t     t;
    a = {waddr, 2'b00};
    t = TGT_NONE;
    if (a >= TIMER_BASE && a < TIMER_BASE + 32'd12)     t = TGT_TIMER;
    else if (a >= SW_BASE && a < SW_BASE + 32'd8)       t = TGT_SW;
    else if (a >= TUBE_BASE && a < TUBE_BASE + 32'd8)   t = TGT_TUBE;
    else if (a == TUBE_CTL)                             t = TGT_CTL;
    return t;
  endfunction

  // FIFO storage and bookkeeping. count holds every write that has been
  // accepted but not yet completed: an entry keeps its slot through its
  // strobe cycle and the following cycle, so a read only proceeds once the
  // last write has fully landed at the device. pend counts stored entries
  // not yet launched onto the device bus.
  entry_t      fifo [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [1:0]  pend;
  logic        active;      // an entry is on the device bus this cycle
  logic        retire;      // the entry launched last cycle frees its slot
  target_t     drain_tgt;

  logic [31:2] dev_addr_q;
  logic [31:0] dev_wdata_q;
  logic [3:0]  dev_byteen_q;
  logic        timer_wen_q;
  logic        tube_wen_q;
  logic        tube_en_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        bus_err_q;

  target_t     cpu_tgt;
  logic        wr_ok;
  logic        rd_ok;
  logic        ready;
  logic        wr_acc;
  logic        rd_acc;
  logic        launch;
  entry_t      incoming;
  entry_t      launch_entry;
  logic [1:0]  count_nxt;
  logic [1:0]  pend_nxt;
  logic [31:0] read_mux;

  assign cpu_tgt = decode(bus.cpu_addr);

  // Readiness comes only from registered occupancy, never from this cycle's drain.
  assign wr_ok  = (count != 2'd2);
  assign rd_ok  = (count == 2'd0);
  assign ready  = bus.cpu_we ? wr_ok : rd_ok;
  assign wr_acc = bus.cpu_req &  bus.cpu_we & ready;
  assign rd_acc = bus.cpu_req & ~bus.cpu_we & ready;

  assign incoming = '{addr:   bus.cpu_addr,
                      byteen: bus.cpu_byteen,
                      wdata:  bus.cpu_wdata,
                      target: cpu_tgt};

  // An empty FIFO forwards the incoming write straight to the device
  // register so it appears on the bus the cycle after acceptance.
  assign launch       = wr_acc | (pend != 2'd0);
  assign launch_entry = (pend != 2'd0) ? fifo[rd_ptr] : incoming;

  assign count_nxt = count + {1'b0, wr_acc} - {1'b0, retire};
  assign pend_nxt  = pend + {1'b0, wr_acc} - {1'b0, launch};

  // Read source select; the display enable reads back as bit 0.
  always_comb begin
    read_mux = '0;
    case (cpu_tgt)
      TGT_TIMER: read_mux = bus.timer_rdata;
      TGT_SW:    read_mux = bus.sw_rdata;
      TGT_TUBE:  read_mux = bus.tube_rdata;
      TGT_CTL:   read_mux = {31'b0, tube_en_q};
      default:   read_mux = '0;
    endcase
  end

  // FIFO payload storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      fifo[wr_ptr] <= incoming;
    end
  end

  // Queue control, device launch, drain side effects and read return.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
      pend         <= 2'd0;
      active       <= 1'b0;
      retire       <= 1'b0;
      drain_tgt    <= TGT_NONE;
      dev_addr_q   <= '0;
      dev_wdata_q  <= '0;
      dev_byteen_q <= '0;
      timer_wen_q  <= 1'b0;
      tube_wen_q   <= 1'b0;
      tube_en_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      count  <= count_nxt;
      pend   <= pend_nxt;
      active <= launch;
      retire <= active;
      if (wr_acc) wr_ptr <= ~wr_ptr;
      if (launch) rd_ptr <= ~rd_ptr;

      drain_tgt    <= launch ? launch_entry.target : TGT_NONE;
      dev_addr_q   <= launch ? launch_entry.addr   : '0;
      dev_wdata_q  <= launch ? launch_entry.wdata  : '0;
      dev_byteen_q <= launch ? launch_entry.byteen : '0;
      timer_wen_q  <= launch && (launch_entry.target == TGT_TIMER);
      tube_wen_q   <= launch && (launch_entry.target == TGT_TUBE);

      // Drain cycle: control word updates the enable, dropped writes flag.
      if (active) begin
        if (drain_tgt == TGT_CTL && dev_byteen_q[0]) tube_en_q <= dev_wdata_q[0];
        if (drain_tgt == TGT_SW || drain_tgt == TGT_NONE) bus_err_q <= 1'b1;
      end

      rvalid_q <= rd_acc;
      if (rd_acc) begin
        rdata_q <= read_mux;
        if (cpu_tgt == TGT_NONE) bus_err_q <= 1'b1;
      end
    end
  end

  assign bus.cpu_ready  = ready;
  assign bus.cpu_rvalid = rvalid_q;
  assign bus.cpu_rdata  = rdata_q;
  assign bus.bus_err    = bus_err_q;
  assign bus.dev_addr   = dev_addr_q;
  assign bus.dev_wdata  = dev_wdata_q;
  assign bus.dev_byteen = dev_byteen_q;
  assign bus.timer_wen  = timer_wen_q;
  assign bus.tube_wen   = tube_wen_q;
  assign bus.tube_en    = tube_en_q;

endmodule
`default_nettype wire

// File: tb/tb_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_bridge
//  Description : Self-checking bench for io_bridge: vector table of single
//                transactions plus hand-written multi-cycle sequences, with
//                a scoreboard for device strobes and read returns.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_io_bridge;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  io_bridge_if bus ();

  io_bridge dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 no strobe, 1 timer_wen, 2 tube_wen
  typedef struct {
    logic [31:0] kind;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          due;
  } wr_exp_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] timer_v;
    logic [31:0] sw_v;
    logic [31:0] tube_v;
    logic [31:0] kind;
    logic [31:0] exp_rd;
    logic        exp_ten;
    logic        exp_err;
  } vec_t;

  wr_exp_t sb_wr[$];
  rd_exp_t sb_rd[$];
  wr_exp_t mon_w;
  rd_exp_t mon_r;
  logic [31:0] last_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: compares every strobe and read return against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      sb_wr.delete();
      sb_rd.delete();
      last_rdata = '0;
    end else begin
      if (bus.timer_wen || bus.tube_wen) begin
        if (sb_wr.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_strobe: timer_wen=%0b tube_wen=%0b at cycle %0d, required none",
                   bus.timer_wen, bus.tube_wen, cyc);
        end else begin
          mon_w = sb_wr.pop_front();
          check("strobe_kind", {30'd0, bus.tube_wen, bus.timer_wen}, mon_w.kind);
          check("dev_addr", {2'b00, bus.dev_addr}, {2'b00, mon_w.addr});
          check("dev_wdata", bus.dev_wdata, mon_w.wdata);
          check("dev_byteen", {28'd0, bus.dev_byteen}, {28'd0, mon_w.be});
          check("strobe_cycle", cyc, mon_w.due);
        end
      end
      if (bus.cpu_rvalid) begin
        if (sb_rd.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rvalid: rdata 0x%08h at cycle %0d, required none", bus.cpu_rdata, cyc);
        end else begin
          mon_r = sb_rd.pop_front();
          check("cpu_rdata", bus.cpu_rdata, mon_r.data);
          check("rvalid_cycle", cyc, mon_r.due);
        end
        last_rdata = bus.cpu_rdata;
      end else begin
        check("rdata_hold", bus.cpu_rdata, last_rdata);
      end
    end
  end

  // Issue one request, holding it until accepted; called just after a posedge.
  task automatic do_req(input bit we, input logic [31:0] baddr, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] kind,
                        input logic [31:0] exp_rd, output int stalls);
    bit      done;
    wr_exp_t we_e;
    rd_exp_t re_e;
    done   = 1'b0;
    stalls = 0;
    bus.cpu_req    = 1'b1;
    bus.cpu_we     = we;
    bus.cpu_addr   = baddr[31:2];
    bus.cpu_byteen = be;
    bus.cpu_wdata  = wd;
    while (!done) begin
      @(negedge clk);
      if (bus.cpu_ready) begin
        done = 1'b1;
        if (we && kind != 0) begin
          we_e.kind  = kind;
          we_e.addr  = baddr[31:2];
          we_e.wdata = wd;
          we_e.be    = be;
          we_e.due   = cyc + 1;
          sb_wr.push_back(we_e);
        end
        if (!we) begin
          re_e.data = exp_rd;
          re_e.due  = cyc + 1;
          sb_rd.push_back(re_e);
        end
      end else begin
        stalls++;
        if (stalls > 20) begin
          n_tests++;
          n_fail++;
          $display("FAIL req_timeout: request at 0x%08h not accepted after %0d cycles", baddr, stalls);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.cpu_req    = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_byteen = '0;
    bus.cpu_wdata  = '0;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_cpu_ready", {31'd0, bus.cpu_ready}, 32'd1);
    check("rst_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
    check("rst_rdata", bus.cpu_rdata, 32'd0);
    check("rst_bus_err", {31'd0, bus.bus_err}, 32'd0);
    check("rst_tube_en", {31'd0, bus.tube_en}, 32'd0);
    check("rst_strobes", {30'd0, bus.tube_wen, bus.timer_wen}, 32'd0);
    check("rst_dev_addr", {2'b00, bus.dev_addr}, 32'd0);
    check("rst_dev_wdata", bus.dev_wdata, 32'd0);
    check("rst_dev_byteen", {28'd0, bus.dev_byteen}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t vec[17];

  initial begin
    int st;
    bus.cpu_req     = 1'b0;
    bus.cpu_we      = 1'b0;
    bus.cpu_addr    = '0;
    bus.cpu_byteen  = '0;
    bus.cpu_wdata   = '0;
    bus.timer_rdata = '0;
    bus.sw_rdata    = '0;
    bus.tube_rdata  = '0;

    //           we  addr         be     wdata         timer         sw            tube          kind exp_rd        ten  err
    vec[0]  = '{1'b1, 32'h7F50, 4'hF, 32'h12345678, 32'h0,        32'h0,        32'h0,        2, 32'h0,        1'b0, 1'b0};
    vec[1]  = '{1'b1, 32'h7F08, 4'h3, 32'hCAFEF00D, 32'h0,        32'h0,        32'h0,        1, 32'h0,        1'b0, 1'b0};
    vec[2]  = '{1'b1, 32'h7F00, 4'hF, 32'h00000055, 32'h0,        32'h0,        32'h0,        1, 32'h0,        1'b0, 1'b0};
    vec[3]  = '{1'b1, 32'h7F54, 4'hC, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        2, 32'h0,        1'b0, 1'b0};
    vec[4]  = '{1'b0, 32'h7F2C, 4'h0, 32'h0,        32'h11111111, 32'hA5A5A5A5, 32'h22222222, 0, 32'hA5A5A5A5, 1'b0, 1'b0};
    vec[5]  = '{1'b0, 32'h7F30, 4'h0, 32'h0,        32'h11111111, 32'h5A5A0F0F, 32'h22222222, 0, 32'h5A5A0F0F, 1'b0, 1'b0};
    vec[6]  = '{1'b0, 32'h7F08, 4'h0, 32'h0,        32'h13572468, 32'h33333333, 32'h22222222, 0, 32'h13572468, 1'b0, 1'b0};
    vec[7]  = '{1'b0, 32'h7F50, 4'h0, 32'h0,        32'h11111111, 32'h33333333, 32'h89ABCDEF, 0, 32'h89ABCDEF, 1'b0, 1'b0};
    vec[8]  = '{1'b0, 32'h7F58, 4'h0, 32'h0,        32'h11111111, 32'h33333333, 32'h22222222, 0, 32'h0,        1'b0, 1'b0};
    vec[9]  = '{1'b1, 32'h7F58, 4'h1, 32'h00000001, 32'h0,        32'h0,        32'h0,        0, 32'h0,        1'b1, 1'b0};
    vec[10] = '{1'b0, 32'h7F58, 4'h0, 32'h0,        32'h11111111, 32'h33333333, 32'h22222222, 0, 32'h00000001, 1'b1, 1'b0};
    vec[11] = '{1'b1, 32'h7F58, 4'hE, 32'h00000000, 32'h0,        32'h0,        32'h0,        0, 32'h0,        1'b1, 1'b0};
    vec[12] = '{1'b1, 32'h7F58, 4'h1, 32'hFFFFFFFE, 32'h0,        32'h0,        32'h0,        0, 32'h0,        1'b0, 1'b0};
    vec[13] = '{1'b1, 32'h7F2C, 4'hF, 32'h0000FFFF, 32'h0,        32'h0,        32'h0,        0, 32'h0,        1'b0, 1'b1};
    vec[14] = '{1'b1, 32'h7F0C, 4'hF, 32'h00000001, 32'h0,        32'h0,        32'h0,        0, 32'h0,        1'b0, 1'b1};
    vec[15] = '{1'b0, 32'h7F4C, 4'h0, 32'h0,        32'h11111111, 32'h33333333, 32'h22222222, 0, 32'h0,        1'b0, 1'b1};
    vec[16] = '{1'b0, 32'h7F5C, 4'h0, 32'h0,        32'h11111111, 32'h33333333, 32'h22222222, 0, 32'h0,        1'b0, 1'b1};

    apply_reset();

    // Single transactions on an idle bridge
    for (int i = 0; i < 17; i++) begin
      bus.timer_rdata = vec[i].timer_v;
      bus.sw_rdata    = vec[i].sw_v;
      bus.tube_rdata  = vec[i].tube_v;
      do_req(vec[i].we, vec[i].addr, vec[i].be, vec[i].wdata, vec[i].kind, vec[i].exp_rd, st);
      check("vec_stalls", st, 32'd0);
      idle(4);
      check("vec_tube_en", {31'd0, bus.tube_en}, {31'd0, vec[i].exp_ten});
      check("vec_bus_err", {31'd0, bus.bus_err}, {31'd0, vec[i].exp_err});
    end

    // Three back-to-back writes: the third waits for a slot, order preserved
    apply_reset();
    do_req(1'b1, 32'h7F00, 4'hF, 32'hA0000001, 1, 32'h0, st);
    check("b2b_w1_stalls", st, 32'd0);
    do_req(1'b1, 32'h7F54, 4'hF, 32'hB0000002, 2, 32'h0, st);
    check("b2b_w2_stalls", st, 32'd0);
    do_req(1'b1, 32'h7F50, 4'hF, 32'hC0000003, 2, 32'h0, st);
    check("b2b_w3_stalls", st, 32'd1);
    idle(6);

    // Control write followed at once by a read of it
    do_req(1'b1, 32'h7F58, 4'hF, 32'h00000001, 0, 32'h0, st);
    do_req(1'b0, 32'h7F58, 4'h0, 32'h0, 0, 32'h00000001, st);
    check("raw_read_stalls", st, 32'd2);
    idle(3);
    check("raw_tube_en", {31'd0, bus.tube_en}, 32'd1);
    check("raw_bus_err", {31'd0, bus.bus_err}, 32'd0);

    // Unmapped write then read: dropped, zero data, sticky error
    apply_reset();
    bus.timer_rdata = 32'hFFFFFFFF;
    bus.sw_rdata    = 32'hFFFFFFFF;
    bus.tube_rdata  = 32'hFFFFFFFF;
    do_req(1'b1, 32'h4000, 4'hF, 32'h87654321, 0, 32'h0, st);
    do_req(1'b0, 32'h4000, 4'h0, 32'h0, 0, 32'h0, st);
    check("unmapped_read_stalls", st, 32'd2);
    idle(3);
    check("unmapped_bus_err", {31'd0, bus.bus_err}, 32'd1);
    idle(10);
    check("unmapped_err_sticky", {31'd0, bus.bus_err}, 32'd1);

    // Two writes queued, then a one-cycle reset
    apply_reset();
    do_req(1'b1, 32'h7F58, 4'h1, 32'h00000001, 0, 32'h0, st);
    do_req(1'b1, 32'h7F54, 4'hF, 32'h5555AAAA, 2, 32'h0, st);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_strobes", {30'd0, bus.tube_wen, bus.timer_wen}, 32'd0);
    check("midrst_tube_en", {31'd0, bus.tube_en}, 32'd0);
    check("midrst_cpu_ready", {31'd0, bus.cpu_ready}, 32'd1);
    check("midrst_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
    idle(6);
    check("midrst_tube_en_late", {31'd0, bus.tube_en}, 32'd0);

    check("sb_wr_drained", sb_wr.size(), 32'd0);
    check("sb_rd_drained", sb_rd.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
